route_packer: RTL and testbench



---
 rtl/route_packer_pkg.sv | 38 +++
 rtl/route_packer_fifo.sv | 66 ++++++
 rtl/route_packer.sv | 88 ++++++++
 tb/tb_route_packer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/route_packer_pkg.sv
// Shared widths, output FSM state type and the packet formatting rule for
// route_packer.
package route_packer_pkg;

  localparam int PAYLOAD_W = 6;
  localparam int ROUTE_W   = 5;
  localparam int PKT_W     = 11;
  localparam int ROUTE_LSB = 6;
  localparam int MAX_HOPS  = 5;
  localparam int HOPS_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    RTZ   = 2'd3
  } tx_state_t;

  // Keeps the first `hops` route bits, counted from the MSB (first hop).
  // Every other route position is injected as zero, because the per-hop
  // shifters refill from the bottom with zeros.
  function automatic logic [PKT_W-1:0] format_pkt(
    input logic [PAYLOAD_W-1:0] payload,
    input logic [ROUTE_W-1:0]   route,
    input logic [HOPS_W-1:0]    hops
  );
    logic [ROUTE_W-1:0] mask;
    int                 n;
    n = int'(hops);
    if (n > MAX_HOPS) n = MAX_HOPS;
    mask = '0;
    for (int i = 0; i < ROUTE_W; i++) begin
      if (i < n) mask[ROUTE_W-1-i] = 1'b1;
    end
    return {route & mask, payload};
  endfunction

endpackage

// File: rtl/route_packer_fifo.sv
// DEPTH x PKT_W synchronous FIFO with wrapping pointers, an occupancy count
// and a registered ready flag. The head word is presented combinationally.
module route_packer_fifo
  import route_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PKT_W-1:0] wdata,
  input  logic             pop,
  output logic [PKT_W-1:0] rdata,
  output logic             empty,
  output logic             ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             ready_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push & ready_q;
  assign pop_ok  = pop & (count != '0);
  assign empty   = (count == '0);
  assign ready   = ready_q;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    unique case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // DEPTH is a power of two, so plain increment wraps the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      ready_q <= (count_next < DEPTH_C);
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // decide what is valid, and an unreset array maps onto plain RAM/regfile.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/route_packer.sv
// Network-interface packet injector: formats payload + source route into
// 11-bit packets, buffers them, and issues each over a 4-phase req/ack link.
// Optional macro ROUTE_PACKER_ACK_SYNC_EN adds a 2-flop out_ack synchronizer.
module route_packer
  import route_packer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [ROUTE_W-1:0]   in_route,
  input  logic [HOPS_W-1:0]    in_hops,
  output logic [PKT_W-1:0]     out_data,
  output logic                 out_req,
  input  logic                 out_ack
);

  logic [PKT_W-1:0] pkt;
  logic [PKT_W-1:0] head;
  logic             fifo_empty;
  logic             pop;
  logic             ack_s;
  tx_state_t        state;
  tx_state_t        state_next;

  assign pkt = format_pkt(in_payload, in_route, in_hops);

  route_packer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .wdata (pkt),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .ready (in_ready)
  );

`ifdef ROUTE_PACKER_ACK_SYNC_EN
  logic [1:0] ack_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= 2'b00;
    else        ack_sync <= {ack_sync[0], out_ack};
  end

  assign ack_s = ack_sync[1];
`else
  // Only safe when the fabric model drives out_ack synchronously to clk.
  assign ack_s = out_ack;
`endif

  assign pop = (state == IDLE) && !fifo_empty;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_next = SETUP;
      SETUP:   state_next = REQ;
      REQ:     if (ack_s) state_next = RTZ;
      RTZ:     if (!ack_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state and registered outputs use non-blocking assignments so all
  // of them update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      out_req  <= 1'b0;
      out_data <= '0;
    end else begin
      state   <= state_next;
      out_req <= (state_next == REQ);
      // Bundled data must be settled a full cycle before req rises.
      if (pop) out_data <= head;
    end
  end

endmodule

// File: tb/tb_route_packer.sv
// Self-checking bench for route_packer: directed format/timing/capacity/reset
// steps plus randomized bursts scored against a queue-based reference model.
module tb_route_packer;

  localparam int DEPTH = 4;
`ifdef ROUTE_PACKER_ACK_SYNC_EN
  localparam int ACK_LAT = 2;
`else
  localparam int ACK_LAT = 0;
`endif
  localparam int PERIOD = 4 + 2 * ACK_LAT;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_payload;
  logic [4:0]  in_route;
  logic [2:0]  in_hops;
  logic [10:0] out_data;
  logic        out_req;
  logic        out_ack;

  int          vectors;
  int          miscompares;
  int          cyc;
  logic [10:0] expq [$];

  route_packer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_payload (in_payload),
    .in_route   (in_route),
    .in_hops    (in_hops),
    .out_data   (out_data),
    .out_req    (out_req),
    .out_ack    (out_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model: route bit k of the first min(hops,5) hops lands at
  // packet bit 10-k; payload sits in the low six bits.
  function automatic logic [10:0] model_pkt(input int payload, input int route, input int hops);
    int h;
    int v;
    h = (hops > 5) ? 5 : hops;
    v = payload % 64;
    for (int k = 0; k < h; k++) begin
      if (((route >> (4 - k)) & 1) == 1) v = v + (1 << (10 - k));
    end
    return v[10:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [5:0] p, input logic [4:0] r, input logic [2:0] h,
                      output bit acc);
    @(negedge clk);
    in_valid   = 1'b1;
    in_payload = p;
    in_route   = r;
    in_hops    = h;
    acc        = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc) expq.push_back(model_pkt(int'(p), int'(r), int'(h)));
  endtask

  // Acts as the fabric for one packet: waits for req, checks the bundled
  // data, acks, measures req fall latency, then returns ack to zero.
  task automatic handshake(input string tag, output int rise_cyc);
    int          n;
    logic [10:0] exp;
    n = 0;
    @(negedge clk);
    while (!out_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_req_rise"}, {31'd0, out_req}, 32'd1);
    rise_cyc = cyc;
    exp = expq.pop_front();
    check({tag, "_data"}, {21'd0, out_data}, {21'd0, exp});
    out_ack = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (out_req && n < 50);
    check({tag, "_ack_to_fall"}, n, ACK_LAT + 1);
    @(negedge clk);
    out_ack = 1'b0;
  endtask

  initial begin
    bit acc;
    int r1, r2, r3;
    int k, n;

    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_payload  = '0;
    in_route    = '0;
    in_hops     = '0;
    out_ack     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_req", {31'd0, out_req}, 32'd0);
    check("reset_out_data", {21'd0, out_data}, 32'd0);

    // First packet: full route, five hops; also the load/req timing.
    push(6'h2A, 5'b10110, 3'd5, acc);
    check("v1_accept", {31'd0, acc}, 32'd1);
    check("v1_data_before_e1", {21'd0, out_data}, 32'd0);
    @(posedge clk);
    #1;
    check("v1_data_after_e1", {21'd0, out_data}, 32'h5AA);
    check("v1_req_low_e1", {31'd0, out_req}, 32'd0);
    @(posedge clk);
    #1;
    check("v1_req_high_e2", {31'd0, out_req}, 32'd1);
    handshake("v1", r1);
    repeat (10) @(posedge clk);
    #1;
    check("v1_data_hold", {21'd0, out_data}, 32'h5AA);

    push(6'h05, 5'b11111, 3'd2, acc);
    handshake("v2", r1);
    check("v2_literal", {21'd0, out_data}, 32'h605);

    push(6'h05, 5'b11111, 3'd7, acc);
    handshake("v3_clamp", r1);
    check("v3_literal", {21'd0, out_data}, 32'h7C5);

    push(6'h3F, 5'b11111, 3'd0, acc);
    handshake("v4_hops0", r1);
    check("v4_literal", {21'd0, out_data}, 32'h03F);

    // Capacity: ack held low, keep offering; DEPTH+1 accepted.
    for (int i = 0; i < DEPTH + 3; i++) begin
      push(6'(i + 1), 5'(i * 7), 3'(i), acc);
      check($sformatf("cap_accept_%0d", i), {31'd0, acc}, (i < DEPTH + 1) ? 32'd1 : 32'd0);
    end
    check("cap_in_ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < DEPTH + 1; i++) handshake($sformatf("drain%0d", i), r1);

    // Back-to-back packets with prompt ack: steady packet period.
    for (int i = 0; i < 3; i++) push(6'(8 * i + 3), 5'b01101, 3'd4, acc);
    handshake("per1", r1);
    handshake("per2", r2);
    handshake("per3", r3);
    check("period_1_2", r2 - r1, PERIOD);
    check("period_2_3", r3 - r2, PERIOD);

    // Randomized bursts up to full capacity, drained in order.
    for (int round = 0; round < 20; round++) begin
      k = $urandom_range(1, DEPTH + 1);
      for (int j = 0; j < k; j++) begin
        push(6'($urandom()), 5'($urandom()), 3'($urandom_range(0, 7)), acc);
        check($sformatf("rnd%0d_accept%0d", round, j), {31'd0, acc}, 32'd1);
      end
      for (int j = 0; j < k; j++) handshake($sformatf("rnd%0d_%0d", round, j), r1);
    end

    // Reset in the middle of a handshake.
    push(6'h11, 5'b10101, 3'd3, acc);
    push(6'h22, 5'b01010, 3'd5, acc);
    n = 0;
    while (!out_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("mid_req_rise", {31'd0, out_req}, 32'd1);
    out_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset_req", {31'd0, out_req}, 32'd0);
    check("mid_reset_data", {21'd0, out_data}, 32'd0);
    out_ack = 1'b0;
    expq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_reset_req", {31'd0, out_req}, 32'd0);
    check("post_reset_data", {21'd0, out_data}, 32'd0);
    push(6'h2A, 5'b10110, 3'd5, acc);
    @(posedge clk);
    #1;
    check("restart_data_e1", {21'd0, out_data}, 32'h5AA);
    handshake("restart", r1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
